// File: rtl/timer_pkg.sv
// Shared definitions for the programmable delay timer: FSM state type,
// mode encodings and default sizing constants.
package timer_pkg;

    // Controller states; encoding is private to the timer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_PRE_W = 8;

    // Cycles in one second of the 50 MHz board clock.
    localparam int CYCLES_1S = 50_000_000;

endpackage

// File: rtl/delay_timer_if.sv
// Requester <-> timer bundle. The master drives start/abort and the load
// values; the slave (the timer) reports busy/done/tick/remaining.
interface delay_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PRE_W = DEFAULT_PRE_W
);
    logic             start;
    logic             abort;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic [PRE_W-1:0] prescale;
    logic             busy;
    logic             done;
    logic             tick;
    logic [WIDTH-1:0] remaining;

    modport master (
        output start, abort, mode, count, prescale,
        input  busy, done, tick, remaining
    );

    modport slave (
        input  start, abort, mode, count, prescale,
        output busy, done, tick, remaining
    );
endinterface

// File: rtl/prescaler.sv
// Prescale down-counter. A load captures both the starting value and the
// reload value; while enabled it counts down and, on reaching zero, reloads
// itself. tc flags the zero state so the owner can step its unit counter.
module prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] load_val,
    output logic             tc
);
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] reload_q, reload_d;

    assign tc = (pre_q == '0);

    // Next-count selection: clear beats load beats counting.
    always_comb begin
        pre_d    = pre_q;
        reload_d = reload_q;
        if (clr) begin
            pre_d = '0;
        end else if (load) begin
            pre_d    = load_val;
            reload_d = load_val;
        end else if (en) begin
            pre_d = tc ? reload_q : pre_q - 1'b1;
        end
    end

    // Counter and latched reload value registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q    <= '0;
            reload_q <= '0;
        end else begin
            pre_q    <= pre_d;
            reload_q <= reload_d;
        end
    end
endmodule

// File: rtl/delay_timer.sv
// Programmable delay timer. A one-cycle start loads a unit count and a
// prescale; each unit lasts prescale+1 clocks. Expiry is reported as a
// sticky done (one-shot) or a tick stream (periodic). abort and start may
// interrupt a running delay at any time.
module delay_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PRE_W = DEFAULT_PRE_W
) (
    input  logic          clk,
    input  logic          rst,
    delay_timer_if.slave  bus
);
    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_load_q, cnt_load_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;

    logic             pre_load;
    logic             pre_clr;
    logic             pre_en;
    logic             pre_tc;
    logic [WIDTH-1:0] count_eff;

    // A zero count would never expire; treat it as a single unit.
    assign count_eff = (bus.count == '0) ? WIDTH'(1) : bus.count;

    prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .load     (pre_load),
        .clr      (pre_clr),
        .en       (pre_en),
        .load_val (bus.prescale),
        .tc       (pre_tc)
    );

    // Next-state logic; priority is abort, then start, then expiry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_load_d = cnt_load_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = done_q;
        tick_d     = 1'b0;
        pre_load   = 1'b0;
        pre_clr    = 1'b0;
        pre_en     = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
            pre_clr = 1'b1;
        end else if (bus.start) begin
            // Fresh load; an interval interrupted here never ticks.
            state_d    = RUN;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            cnt_d      = count_eff;
            cnt_load_d = count_eff;
            mode_d     = bus.mode;
            pre_load   = 1'b1;
        end else if (state_q == RUN) begin
            pre_en = 1'b1;
            if (pre_tc) begin
                if (cnt_q == WIDTH'(1)) begin
                    tick_d = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        // Prescaler reloads itself on tc; restart the units.
                        cnt_d = cnt_load_q;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        pre_en  = 1'b0;
                        pre_clr = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // State, unit counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cnt_load_q <= '0;
            mode_q     <= MODE_ONESHOT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cnt_load_q <= cnt_load_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.tick      = tick_q;
    assign bus.remaining = cnt_q;
endmodule

// File: tb/tb_delay_timer.sv
// Self-checking bench for delay_timer. Expected tick cycles are queued when a
// start is issued; a monitor pops and compares them whenever tick is seen.
module tb_delay_timer;
    import timer_pkg::*;

    localparam int WIDTH = 32;
    localparam int PRE_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    delay_timer_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

    delay_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    task automatic drive(input bit st, input bit ab, input bit m,
                         input int unsigned c, input int unsigned p);
        bus.start    = st;
        bus.abort    = ab;
        bus.mode     = m;
        bus.count    = c;
        bus.prescale = PRE_W'(p);
    endtask

    // Issue a one-cycle start; returns the index of the edge that took it.
    task automatic launch(input bit m, input int unsigned c, input int unsigned p,
                          output int c0);
        @(negedge clk);
        drive(1'b1, 1'b0, m, c, p);
        @(negedge clk);
        drive(1'b0, 1'b0, m, c, p);
        c0 = cyc;
    endtask

    task automatic go_idle();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Scoreboard consumer: every observed tick must match the queue head.
    task automatic tick_monitor();
        int e;
        forever begin
            @(negedge clk);
            if (rst && bus.tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tick_unexpected at cyc=%0d got tick=1 want tick=0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e) begin
                        failures++;
                        $display("FAIL tick_cycle got cyc=%0d want cyc=%0d", cyc, e);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 5, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b want=0", bus.done); end
        checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL rst_tick got=%0b want=0", bus.tick); end
        checks++; if (bus.remaining !== '0) begin failures++; $display("FAIL rst_remaining got=%0d want=0", bus.remaining); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL idle_done got=%0b want=0", bus.done); end
        checks++; if (bus.remaining !== '0) begin failures++; $display("FAIL idle_remaining got=%0d want=0", bus.remaining); end
    endtask

    task automatic test_oneshot();
        int c0;
        launch(MODE_ONESHOT, 5, 0, c0);
        exp_q.push_back(c0 + 5);
        for (int k = 0; k <= 8; k++) begin
            logic [WIDTH-1:0] exp_rem;
            exp_rem = (k < 5) ? WIDTH'(5 - k) : '0;
            checks++; if (bus.busy !== (k < 5)) begin failures++; $display("FAIL os_busy k=%0d got=%0b want=%0b", k, bus.busy, (k < 5)); end
            checks++; if (bus.done !== (k >= 5)) begin failures++; $display("FAIL os_done k=%0d got=%0b want=%0b", k, bus.done, (k >= 5)); end
            checks++; if (bus.remaining !== exp_rem) begin failures++; $display("FAIL os_remaining k=%0d got=%0d want=%0d", k, bus.remaining, exp_rem); end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL os_missing_ticks got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
        // count=0 behaves as count=1; restarting straight out of DONE.
        launch(MODE_ONESHOT, 0, 0, c0);
        exp_q.push_back(c0 + 1);
        for (int k = 0; k <= 3; k++) begin
            checks++; if (bus.done !== (k >= 1)) begin failures++; $display("FAIL os0_done k=%0d got=%0b want=%0b", k, bus.done, (k >= 1)); end
            checks++; if (bus.busy !== (k < 1)) begin failures++; $display("FAIL os0_busy k=%0d got=%0b want=%0b", k, bus.busy, (k < 1)); end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL os0_missing_ticks got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
        go_idle();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_clears_done got=%0b want=0", bus.done); end
    endtask

    task automatic test_prescaled();
        int c0;
        launch(MODE_ONESHOT, 3, 3, c0);
        exp_q.push_back(c0 + 12);
        for (int k = 0; k <= 14; k++) begin
            logic [WIDTH-1:0] exp_rem;
            exp_rem = (k >= 12) ? '0 : WIDTH'(3 - k / 4);
            checks++; if (bus.remaining !== exp_rem) begin failures++; $display("FAIL pre_remaining k=%0d got=%0d want=%0d", k, bus.remaining, exp_rem); end
            checks++; if (bus.busy !== (k < 12)) begin failures++; $display("FAIL pre_busy k=%0d got=%0b want=%0b", k, bus.busy, (k < 12)); end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pre_missing_ticks got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
        go_idle();
    endtask

    task automatic test_periodic();
        int c0;
        launch(MODE_PERIODIC, 4, 1, c0);
        exp_q.push_back(c0 + 8);
        exp_q.push_back(c0 + 16);
        for (int k = 0; k <= 26; k++) begin
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL per_done k=%0d got=%0b want=0", k, bus.done); end
            checks++; if (bus.busy !== (k < 20)) begin failures++; $display("FAIL per_busy k=%0d got=%0b want=%0b", k, bus.busy, (k < 20)); end
            drive(1'b0, (k == 19), MODE_PERIODIC, 4, 1);
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL per_missing_ticks got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
        // N=1: tick stays high every cycle until aborted.
        launch(MODE_PERIODIC, 1, 0, c0);
        for (int i = 1; i <= 4; i++) exp_q.push_back(c0 + i);
        for (int k = 0; k <= 6; k++) begin
            checks++; if (bus.tick !== (k >= 1 && k <= 4)) begin failures++; $display("FAIL per1_tick k=%0d got=%0b want=%0b", k, bus.tick, (k >= 1 && k <= 4)); end
            drive(1'b0, (k == 4), MODE_PERIODIC, 1, 0);
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL per1_missing_ticks got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_restart();
        int c0;
        launch(MODE_ONESHOT, 10, 0, c0);
        exp_q.push_back(c0 + 8);
        for (int k = 0; k <= 12; k++) begin
            logic [WIDTH-1:0] exp_rem;
            exp_rem = (k < 6) ? WIDTH'(10 - k) : (k < 8) ? WIDTH'(8 - k) : '0;
            checks++; if (bus.remaining !== exp_rem) begin failures++; $display("FAIL rs_remaining k=%0d got=%0d want=%0d", k, bus.remaining, exp_rem); end
            checks++; if (bus.done !== (k >= 8)) begin failures++; $display("FAIL rs_done k=%0d got=%0b want=%0b", k, bus.done, (k >= 8)); end
            drive((k == 5), 1'b0, MODE_ONESHOT, 2, 0);
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rs_missing_ticks got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int c0;
        // Restart lands exactly on the second expiry (edge c0+6): no tick there.
        launch(MODE_PERIODIC, 3, 0, c0);
        exp_q.push_back(c0 + 3);
        exp_q.push_back(c0 + 8);
        exp_q.push_back(c0 + 10);
        for (int k = 0; k <= 13; k++) begin
            checks++; if (bus.busy !== (k < 11)) begin failures++; $display("FAIL col_busy k=%0d got=%0b want=%0b", k, bus.busy, (k < 11)); end
            drive((k == 5), (k == 10), MODE_PERIODIC, 2, 0);
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL col_missing_ticks got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_async_reset();
        int c0;
        launch(MODE_ONESHOT, 10, 0, c0);
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ar_busy_before got=%0b want=1", bus.busy); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%0b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL ar_done got=%0b want=0", bus.done); end
        checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL ar_tick got=%0b want=0", bus.tick); end
        checks++; if (bus.remaining !== '0) begin failures++; $display("FAIL ar_remaining got=%0d want=0", bus.remaining); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ar_idle_busy got=%0b want=0", bus.busy); end
        launch(MODE_ONESHOT, 2, 0, c0);
        exp_q.push_back(c0 + 2);
        for (int k = 0; k <= 4; k++) begin
            checks++; if (bus.done !== (k >= 2)) begin failures++; $display("FAIL ar_done_after k=%0d got=%0b want=%0b", k, bus.done, (k >= 2)); end
            checks++; if (bus.busy !== (k < 2)) begin failures++; $display("FAIL ar_busy_after k=%0d got=%0b want=%0b", k, bus.busy, (k < 2)); end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ar_missing_ticks got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        fork
            tick_monitor();
        join_none
        test_reset();
        test_oneshot();
        test_prescaled();
        test_periodic();
        test_restart();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
